// File: rtl/pipe_pkg.sv
// Shared types and widths for the MEM pipeline stage.
package pipe_pkg;

  localparam int unsigned WORD    = 32;
  localparam int unsigned REGADDR = 5;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // EXE/MEM pipeline register payload
  typedef struct packed {
    logic [WORD-1:0]    alu;
    logic [WORD-1:0]    b;
    logic [REGADDR-1:0] rn;
    logic               wreg;
    logic               m2reg;
    logic               wmem;
  } em_t;

  function automatic logic is_mem_op(input em_t e);
    return e.m2reg | e.wmem;
  endfunction

  function automatic logic is_aligned(input logic [WORD-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/pipeemreg.sv
// EXE/MEM pipeline register with load enable and an occupied flag.
module pipeemreg
  import pipe_pkg::*;
(
  input  logic clock,
  input  logic resetn,
  input  logic en,
  input  em_t  d,
  output em_t  q,
  output logic occupied
);

  em_t  em_q, em_d;
  logic occ_q, occ_d;

  always_comb begin
    em_d  = em_q;
    occ_d = occ_q;
    if (en) begin
      em_d  = d;
      occ_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      em_q  <= '0;
      occ_q <= 1'b0;
    end else begin
      em_q  <= em_d;
      occ_q <= occ_d;
    end
  end

  assign q        = em_q;
  assign occupied = occ_q;

endmodule

// File: rtl/pipemem_access.sv
// MEM stage: EXE/MEM register, one memory transaction per load/store,
// pipeline stall while outstanding, and MEM/WB input generation.
module pipemem_access
  import pipe_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [WORD-1:0]    ealu,
  input  logic [WORD-1:0]    eb,
  input  logic [REGADDR-1:0] ern,
  input  logic               ewreg,
  input  logic               em2reg,
  input  logic               ewmem,
  output logic               mem_req,
  output logic               mem_we,
  output logic [WORD-1:0]    mem_addr,
  output logic [WORD-1:0]    mem_wdata,
  input  logic               mem_ready,
  input  logic [WORD-1:0]    mem_rdata,
  output logic               stall,
  output logic               mvalid,
  output logic [WORD-1:0]    malu,
  output logic [WORD-1:0]    mmo,
  output logic [REGADDR-1:0] mrn,
  output logic               mwreg,
  output logic               mm2reg,
  output logic               merr
);

  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  em_t              e_in;
  em_t              em;
  logic             occupied;
  logic             waiting;
  logic             under_limit;
  logic             timeout;

  assign e_in = '{alu: ealu, b: eb, rn: ern, wreg: ewreg, m2reg: em2reg, wmem: ewmem};

  pipeemreg u_emreg (
    .clock    (clock),
    .resetn   (resetn),
    .en       (~stall),
    .d        (e_in),
    .q        (em),
    .occupied (occupied)
  );

  // Timeout only when the memory has still not answered at the limit
  assign waiting     = (state_q == ACCESS) & ~mem_ready;
  assign under_limit = cnt_q < MAX_WAIT_C;
  assign timeout     = waiting & ~under_limit;
  assign stall       = waiting & under_limit;

  // Next state follows whatever instruction is captured at the same edge
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (stall) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (is_mem_op(e_in) && is_aligned(ealu)) begin
      state_d = ACCESS;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Completion and fault flags for the instruction held in EXE/MEM
  always_comb begin
    mvalid = 1'b0;
    merr   = 1'b0;
    if (state_q == ACCESS) begin
      mvalid = mem_ready | timeout;
      merr   = timeout;
    end else begin
      mvalid = occupied;
      merr   = occupied & is_mem_op(em) & ~is_aligned(em.alu);
    end
  end

  assign mwreg     = em.wreg & mvalid & ~merr;
  assign mem_req   = (state_q == ACCESS);
  assign mem_we    = em.wmem;
  assign mem_addr  = em.alu;
  assign mem_wdata = em.b;
  assign malu      = em.alu;
  assign mrn       = em.rn;
  assign mm2reg    = em.m2reg;
  assign mmo       = mem_rdata;

endmodule

// File: tb/tb_pipemem_access.sv
// Directed self-checking bench for pipemem_access (MAX_WAIT = 4).
module tb_pipemem_access;

  logic        clock;
  logic        resetn;
  logic [31:0] ealu, eb;
  logic [4:0]  ern;
  logic        ewreg, em2reg, ewmem;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall, mvalid;
  logic [31:0] malu, mmo;
  logic [4:0]  mrn;
  logic        mwreg, mm2reg, merr;

  int n_checks = 0;
  int n_fail   = 0;

  pipemem_access #(.MAX_WAIT(4)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .ealu      (ealu),
    .eb        (eb),
    .ern       (ern),
    .ewreg     (ewreg),
    .em2reg    (em2reg),
    .ewmem     (ewmem),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .stall     (stall),
    .mvalid    (mvalid),
    .malu      (malu),
    .mmo       (mmo),
    .mrn       (mrn),
    .mwreg     (mwreg),
    .mm2reg    (mm2reg),
    .merr      (merr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_e(input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn,
                       input logic wreg, input logic m2reg, input logic wmem);
    ealu = alu; eb = b; ern = rn; ewreg = wreg; em2reg = m2reg; ewmem = wmem;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic samp();
    @(negedge clock);
  endtask

  initial begin
    resetn    = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    set_e(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);

    #3;
    check("rst_req",    32'(mem_req), 32'd0);
    check("rst_stall",  32'(stall),   32'd0);
    check("rst_mvalid", 32'(mvalid),  32'd0);
    check("rst_mwreg",  32'(mwreg),   32'd0);
    check("rst_merr",   32'(merr),    32'd0);
    check("rst_malu",   malu,         32'd0);
    cyc();
    resetn = 1'b1;

    // Three back-to-back adds
    set_e(32'd5, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) set_e(32'(6 + i), 32'h0, 5'd8, 1'b1, 1'b0, 1'b0);
      else       set_e(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
      samp();
      check("add_mvalid", 32'(mvalid), 32'd1);
      check("add_malu",   malu,        32'(5 + i));
      check("add_mwreg",  32'(mwreg),  32'd1);
      check("add_mrn",    32'(mrn),    32'd8);
      check("add_stall",  32'(stall),  32'd0);
      cyc();
    end

    // Load with two wait cycles
    set_e(32'h100, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0);
    cyc();
    set_e(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      samp();
      check("ld_req",    32'(mem_req), 32'd1);
      check("ld_addr",   mem_addr,     32'h100);
      check("ld_we",     32'(mem_we),  32'd0);
      check("ld_stall",  32'(stall),   32'd1);
      check("ld_mvalid", 32'(mvalid),  32'd0);
      cyc();
    end
    mem_ready = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    samp();
    check("ld_done_stall",  32'(stall),  32'd0);
    check("ld_done_mvalid", 32'(mvalid), 32'd1);
    check("ld_done_mmo",    mmo,         32'hDEADBEEF);
    check("ld_done_mwreg",  32'(mwreg),  32'd1);
    check("ld_done_mrn",    32'(mrn),    32'd9);
    check("ld_done_merr",   32'(merr),   32'd0);
    cyc();
    mem_ready = 1'b0;
    samp();
    check("ld_after_req", 32'(mem_req), 32'd0);

    // Store then load, memory always ready
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    set_e(32'h40, 32'h12345678, 5'd0, 1'b0, 1'b0, 1'b1);
    cyc();
    set_e(32'h40, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0);
    samp();
    check("st_req",    32'(mem_req), 32'd1);
    check("st_we",     32'(mem_we),  32'd1);
    check("st_addr",   mem_addr,     32'h40);
    check("st_wdata",  mem_wdata,    32'h12345678);
    check("st_stall",  32'(stall),   32'd0);
    check("st_mvalid", 32'(mvalid),  32'd1);
    check("st_mwreg",  32'(mwreg),   32'd0);
    cyc();
    set_e(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    samp();
    check("ld2_req",   32'(mem_req), 32'd1);
    check("ld2_we",    32'(mem_we),  32'd0);
    check("ld2_stall", 32'(stall),   32'd0);
    check("ld2_mwreg", 32'(mwreg),   32'd1);
    check("ld2_mmo",   mmo,          32'hCAFEF00D);
    cyc();
    mem_ready = 1'b0;
    samp();
    check("ld2_after_req", 32'(mem_req), 32'd0);

    // Misaligned load
    set_e(32'h102, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0);
    cyc();
    set_e(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    samp();
    check("mis_req",    32'(mem_req), 32'd0);
    check("mis_merr",   32'(merr),    32'd1);
    check("mis_mvalid", 32'(mvalid),  32'd1);
    check("mis_mwreg",  32'(mwreg),   32'd0);
    check("mis_stall",  32'(stall),   32'd0);
    cyc();
    samp();
    check("mis_next_merr", 32'(merr), 32'd0);

    // Store timing out, then the held add proceeds
    set_e(32'h80, 32'hA5A5A5A5, 5'd0, 1'b0, 1'b0, 1'b1);
    cyc();
    set_e(32'h33, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      samp();
      check("to_stall", 32'(stall),   32'd1);
      check("to_req",   32'(mem_req), 32'd1);
      check("to_merr",  32'(merr),    32'd0);
      cyc();
    end
    samp();
    check("to_end_stall",  32'(stall),  32'd0);
    check("to_end_merr",   32'(merr),   32'd1);
    check("to_end_mvalid", 32'(mvalid), 32'd1);
    check("to_end_mwreg",  32'(mwreg),  32'd0);
    cyc();
    set_e(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    samp();
    check("to_res_req",   32'(mem_req), 32'd0);
    check("to_res_malu",  malu,         32'h33);
    check("to_res_mwreg", 32'(mwreg),   32'd1);
    check("to_res_merr",  32'(merr),    32'd0);
    cyc();

    // Ready on the timeout cycle counts as success
    set_e(32'h200, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0);
    cyc();
    set_e(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (4) cyc();
    mem_ready = 1'b1;
    mem_rdata = 32'h5A5A5A5A;
    samp();
    check("race_merr",   32'(merr),   32'd0);
    check("race_mvalid", 32'(mvalid), 32'd1);
    check("race_mwreg",  32'(mwreg),  32'd1);
    check("race_mmo",    mmo,         32'h5A5A5A5A);
    cyc();
    mem_ready = 1'b0;

    // Reset in the middle of a load
    set_e(32'h104, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0);
    cyc();
    set_e(32'h77, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0);
    samp();
    check("rmid_req_pre", 32'(mem_req), 32'd1);
    resetn = 1'b0;
    #1;
    check("rmid_req",    32'(mem_req), 32'd0);
    check("rmid_stall",  32'(stall),   32'd0);
    check("rmid_mvalid", 32'(mvalid),  32'd0);
    check("rmid_mwreg",  32'(mwreg),   32'd0);
    cyc();
    resetn = 1'b1;
    samp();
    check("rmid_idle_mvalid", 32'(mvalid), 32'd0);
    cyc();
    set_e(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    samp();
    check("rmid_add_mvalid", 32'(mvalid),  32'd1);
    check("rmid_add_malu",   malu,         32'h77);
    check("rmid_add_mwreg",  32'(mwreg),   32'd1);
    check("rmid_add_req",    32'(mem_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
